// File: rtl/cyclic_code_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cyclic_code_pkg
// Brief    : Shared constants, encoder state type and parity reference
//            function for the (7,4) cyclic Hamming encoder/decoder pair.
// Revision : 1.0 - initial release
// ============================================================================
package cyclic_code_pkg;

  localparam int         CODE_N     = 7;
  localparam int         CODE_K     = 4;
  localparam int         CODE_R     = CODE_N - CODE_K;
  localparam logic [3:0] CODE_GPOLY = 4'b1011;   // x^3 + x + 1

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    HOLD   = 2'd2
  } enc_state_t;

  // Remainder of x^R * msg(x) divided by g(x); msg[K-1] is the first bit in.
  function automatic logic [CODE_R-1:0] calc_parity(input logic [CODE_K-1:0] msg);
    logic [CODE_R-1:0] rem;
    logic              fb;
    rem = '0;
    for (int i = CODE_K - 1; i >= 0; i--) begin
      fb = msg[i] ^ rem[CODE_R-1];
      for (int j = CODE_R - 1; j > 0; j--) begin
        rem[j] = rem[j-1] ^ (CODE_GPOLY[j] & fb);
      end
      rem[0] = fb;
    end
    return rem;
  endfunction

endpackage : cyclic_code_pkg
`default_nettype wire

// File: rtl/cyclic_lfsr_div.sv
`default_nettype none
// ============================================================================
// Module   : cyclic_lfsr_div
// Brief    : Serial GF(2) polynomial divider (Galois LFSR). One message bit
//            per enabled clock; exposes the remainder including the bit being
//            shifted this cycle so the caller can capture it on the last shift.
// Revision : 1.0 - initial release
// ============================================================================
module cyclic_lfsr_div #(
  parameter int         R     = 3,
  parameter logic [R:0] GPOLY = 4'b1011
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         shift,
  input  logic         data_in,
  output logic [R-1:0] parity
);

  logic [R-1:0] lfsr;
  logic [R-1:0] lfsr_next;
  logic         fb;

  assign fb = data_in ^ lfsr[R-1];

  // Next remainder: feedback enters at x^0 and is folded into each tap of g(x).
  always_comb begin
    lfsr_next    = '0;
    lfsr_next[0] = fb;
    for (int i = 1; i < R; i++) begin
      lfsr_next[i] = lfsr[i-1] ^ (GPOLY[i] & fb);
    end
  end

  // Remainder register: cleared when a new message is accepted, shifts while dividing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= '0;
    end else if (clear) begin
      lfsr <= '0;
    end else if (shift) begin
      lfsr <= lfsr_next;
    end
  end

  assign parity = lfsr_next;

endmodule : cyclic_lfsr_div
`default_nettype wire

// File: rtl/cyclic_encoder_7_4.sv
`default_nettype none
// ============================================================================
// Module   : cyclic_encoder_7_4
// Brief    : Systematic (7,4) cyclic Hamming encoder, g(x) = x^3 + x + 1.
//            Accepts a message over valid/ready, divides x^3*m(x) serially,
//            and presents {msg, parity} over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module cyclic_encoder_7_4
  import cyclic_code_pkg::*;
#(
  parameter int           N     = CODE_N,
  parameter int           K     = CODE_K,
  parameter logic [N-K:0] GPOLY = CODE_GPOLY
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [K-1:0] msg_data,
  output logic         cw_valid,
  input  logic         cw_ready,
  output logic [N-1:0] cw_data,
  output logic         busy
);

  localparam int R  = N - K;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_DIVIDE = DIVIDE;
  localparam logic [1:0] ST_HOLD   = HOLD;

  logic [1:0]    state;
  logic [CW-1:0] bit_cnt;
  logic [K-1:0]  msg_reg;
  logic [R-1:0]  parity;
  logic          accept;
  logic          dividing;
  logic          last_shift;
  logic          msg_bit;

  assign accept     = (state == ST_IDLE) && msg_valid;
  assign dividing   = (state == ST_DIVIDE);
  assign last_shift = dividing && (bit_cnt == '0);
  assign msg_bit    = msg_reg[bit_cnt];

  assign msg_ready  = (state == ST_IDLE);
  assign cw_valid   = (state == ST_HOLD);
  assign busy       = (state == ST_DIVIDE) || (state == ST_HOLD);

  cyclic_lfsr_div #(
    .R     (R),
    .GPOLY (GPOLY)
  ) u_lfsr_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .shift   (dividing),
    .data_in (msg_bit),
    .parity  (parity)
  );

  // Control FSM: latch message, walk the bit counter MSB first, hold the codeword until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      msg_reg <= '0;
      cw_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (msg_valid) begin
            msg_reg <= msg_data;
            bit_cnt <= CW'(K - 1);
            state   <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          if (last_shift) begin
            // Parity seen here already includes the final shift.
            cw_data <= {msg_reg, parity};
            state   <= ST_HOLD;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cw_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : cyclic_encoder_7_4
`default_nettype wire

// File: tb/tb_cyclic_encoder_7_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_cyclic_encoder_7_4
// Brief    : Self-checking bench for cyclic_encoder_7_4 against a polynomial
//            long-division reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cyclic_encoder_7_4;
  import cyclic_code_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       msg_valid;
  logic       msg_ready;
  logic [3:0] msg_data;
  logic       cw_valid;
  logic       cw_ready;
  logic [6:0] cw_data;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  cyclic_encoder_7_4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_data  (msg_data),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .cw_data   (cw_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Remainder of val(x) mod g(x) by long division, g = x^3+x+1 (0xB).
  function automatic logic [2:0] ref_rem(input int unsigned val);
    int unsigned v;
    v = val;
    for (int i = 15; i >= 3; i--) begin
      if (v[i]) v = v ^ (32'hB << (i - 3));
    end
    return v[2:0];
  endfunction

  function automatic logic [6:0] ref_cw(input logic [3:0] m);
    return {m, ref_rem(32'(m) << 3)};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_msg_ready"}, 32'(msg_ready), 32'd1);
    check({tag, "_cw_valid"},  32'(cw_valid),  32'd0);
    check({tag, "_cw_data"},   32'(cw_data),   32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // Called #1 after a posedge with the DUT idle.
  task automatic encode(input logic [3:0] m, input logic [6:0] exp, input int hold_cycles,
                        input bit pre_ready);
    int lat;
    check("model_calc_parity", 32'(calc_parity(m)), 32'(ref_rem(32'(m) << 3)));
    check("model_divisible",   32'(ref_rem(32'(exp))), 32'd0);
    check("idle_ready", 32'(msg_ready), 32'd1);
    msg_valid = 1'b1;
    msg_data  = m;
    cw_ready  = pre_ready;
    @(posedge clk); #1;
    msg_valid = 1'b0;
    msg_data  = 4'($urandom_range(15));
    lat = 0;
    while (!cw_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    check("cw_data", 32'(cw_data), 32'(exp));
    check("hold_busy", 32'(busy), 32'd1);
    check("hold_msg_ready", 32'(msg_ready), 32'd0);
    if (!pre_ready) begin
      for (int i = 0; i < hold_cycles; i++) begin
        msg_valid = (i == 1);
        msg_data  = 4'($urandom_range(15));
        @(posedge clk); #1;
        check("stall_cw_valid", 32'(cw_valid), 32'd1);
        check("stall_cw_data", 32'(cw_data), 32'(exp));
        check("stall_msg_ready", 32'(msg_ready), 32'd0);
      end
      msg_valid = 1'b0;
      cw_ready  = 1'b1;
    end
    @(posedge clk); #1;
    check("post_cw_valid", 32'(cw_valid), 32'd0);
    check("post_msg_ready", 32'(msg_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
    check("post_cw_held", 32'(cw_data), 32'(exp));
    cw_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] q[$];
    logic [3:0] m;
    int         last;
    int         n;

    rst_n     = 1'b0;
    msg_valid = 1'b0;
    msg_data  = 4'd0;
    cw_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed codewords from the code table.
    encode(4'b0001, 7'b0001011, 0, 1'b1);
    encode(4'b1000, 7'b1000101, 0, 1'b0);
    encode(4'b1010, 7'b1010011, 2, 1'b0);
    encode(4'b1111, 7'b1111111, 1, 1'b1);
    encode(4'b0000, 7'b0000000, 0, 1'b0);
    encode(4'b0110, 7'b0110001, 10, 1'b0);

    // All messages, random downstream back-pressure.
    for (int i = 0; i < 16; i++) begin
      encode(4'(i), ref_cw(4'(i)), int'($urandom_range(3)), 1'($urandom_range(1)));
    end

    // Back-to-back stream with downstream always ready.
    msg_valid = 1'b1;
    cw_ready  = 1'b1;
    msg_data  = 4'($urandom_range(15));
    last = -1;
    n    = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (msg_valid && msg_ready) q.push_back(msg_data);
      if (cw_valid && cw_ready) begin
        if (q.size() == 0) begin
          check("b2b_unexpected_cw", 32'(cw_data), 32'hFFFF_FFFF);
        end else begin
          check("b2b_data", 32'(cw_data), 32'(ref_cw(q.pop_front())));
        end
        if (last >= 0) check("b2b_period", 32'(cyc - last), 32'd6);
        last = cyc;
        n++;
      end
      @(posedge clk); #1;
      msg_data = 4'($urandom_range(15));
    end
    msg_valid = 1'b0;
    cw_ready  = 1'b0;
    check("b2b_count", 32'(n), 32'd10);
    check("b2b_leftover", 32'(q.size()), 32'd0);

    // Reset during the second DIVIDE cycle.
    encode(4'b1101, ref_cw(4'b1101), 0, 1'b1);
    msg_valid = 1'b1;
    msg_data  = 4'b1011;
    @(posedge clk); #1;
    msg_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_divide");
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_divide_no_cw", 32'(cw_valid), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    encode(4'b0111, ref_cw(4'b0111), 1, 1'b0);

    // Reset while a codeword is being held.
    msg_valid = 1'b1;
    msg_data  = 4'b1001;
    @(posedge clk); #1;
    msg_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_hold_pre_valid", 32'(cw_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_hold_after_valid", 32'(cw_valid), 32'd0);

    // Random messages with random back-pressure.
    for (int i = 0; i < 20; i++) begin
      m = 4'($urandom_range(15));
      encode(m, ref_cw(m), int'($urandom_range(4)), 1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cyclic_encoder_7_4
`default_nettype wire
